hello_follower: RTL and testbench
=================================

Name: hello_follower

Overview:
- Clocked follower: output b tracks 1-bit input a after synchronization and optional stability filtering.
- Also flags each accepted transition and counts transitions.
- Serves as the minimal registered input-conditioning cell for asynchronous single-bit signals, such as a pin, a test stimulus or a status line, feeding synchronous logic.

Parameters:
- SYNC_STAGES, 2, depth of the input synchronizer flop chain. Legal values ≥2.
- STABLE_CYCLES, 1, consecutive synchronized samples that must differ from b before b updates. Legal values ≥1; 1 means no filtering.
- CNT_W, 16, width of the transition counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  1  asynchronous data input.
- cnt_clr  input  1  synchronous clear of edge_cnt.
- b  output  1  filtered, registered copy of a.
- rise  output  1  one-cycle pulse: b went 0→1 on this edge.
- fall  output  1  one-cycle pulse: b went 1→0 on this edge.
- edge_cnt  output  CNT_W  number of accepted b transitions, saturating.

Behaviour:
- Reset (rst_n=0) takes effect immediately, regardless of clk:
  - synchronizer chain = 0
  - filter counter = 0
  - b = 0, rise = 0, fall = 0, edge_cnt = 0
  - Outputs hold these values while reset is asserted. Operation resumes on the first rising edge after release.
- Reset asserted mid-operation discards any pending, not-yet-accepted change.
- Synchronizer: a shifts through SYNC_STAGES flops each edge; s is the last stage.
- Filter (counter f, range 0..STABLE_CYCLES-1):
  - If s == b: f is cleared to 0 and b holds.
  - If s != b and f == STABLE_CYCLES-1: b takes s and f is cleared.
  - Otherwise, when s != b: f increments.
  - A glitch shorter than STABLE_CYCLES synchronized samples never reaches b.
- Latency: a change of a that is stable and captured at edge k appears on b at edge k + SYNC_STAGES + STABLE_CYCLES - 1. With defaults, b changes 2 edges after the capturing edge.
- rise and fall are registered and update on the same edge as b:
  - rise = 1 for exactly one cycle when b goes 0→1; fall likewise for 1→0.
  - Both are never high together and are 0 in all other cycles.
- edge_cnt:
  - Increments by 1 on each edge where b changes.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 sets it to 0 on the next edge. If cnt_clr and a transition coincide, the clear wins and the result is 0.
- No handshake; a is free-running. b is glitch-free because it is registered directly.

Test Plan (clk period 10 ns):
1. Reset release with a=0 held for 20 ns → b=0, rise=0, fall=0, edge_cnt=0 throughout.
2. a toggled 0→1, held 20 ns, then 1→0, held 20 ns (defaults):
   - b rises 2 edges after capture, with a single rise pulse.
   - b falls 2 edges after the next capture, with a single fall pulse.
   - edge_cnt ends at 2.
3. STABLE_CYCLES=4, a pulsed high for 2 cycles → b, rise and edge_cnt unchanged. Hold a high for 4 cycles → b=1 at capture+SYNC_STAGES+3.
4. CNT_W=2, 5 full toggles of a → edge_cnt saturates at 3. Assert cnt_clr on the same edge as a b transition → edge_cnt=0 while b still updates.
5. rst_n pulled low asynchronously between clock edges while b=1 with a change pending → b, rise, fall and edge_cnt drop to 0 immediately. After release with a=1, b returns to 1 after SYNC_STAGES+STABLE_CYCLES edges.

Source files
------------

// File: rtl/hello_follower.sv
// -----------------------------------------------------------------------------
// hello_follower
//
// Registered input-conditioning cell for an asynchronous single-bit signal.
// The input is first passed through a flop synchronizer. It then goes through
// an optional stability filter before it drives the registered output b.
// Each accepted change of b raises a one-cycle rise or fall pulse and bumps a
// saturating transition counter.
//
// Parameters
//   SYNC_STAGES   : depth of the synchronizer chain (>= 2)
//   STABLE_CYCLES : consecutive synchronized samples that must differ from b
//                   before b follows them (>= 1, 1 = no filtering)
//   CNT_W         : width of the transition counter
//
// Ports
//   clk      in   system clock, rising-edge active
//   rst_n    in   asynchronous active-low reset
//   a        in   asynchronous data input
//   cnt_clr  in   synchronous clear of edge_cnt (wins over an increment)
//   b        out  filtered, registered copy of a
//   rise     out  one-cycle pulse on the edge where b goes 0->1
//   fall     out  one-cycle pulse on the edge where b goes 1->0
//   edge_cnt out  number of accepted b transitions, saturating
// -----------------------------------------------------------------------------
module hello_follower #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             cnt_clr,
    output logic             b,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
);

    // The filter counter only needs to reach STABLE_CYCLES-1. Keep at least
    // one bit so that the unfiltered configuration still elaborates cleanly.
    localparam int unsigned    F_W     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [F_W-1:0] F_LAST  = F_W'(STABLE_CYCLES - 1);
    localparam logic [F_W-1:0] F_ZERO  = {F_W{1'b0}};
    localparam logic [F_W-1:0] F_ONE   = F_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out_s;
    logic [F_W-1:0]         f_q;
    logic [F_W-1:0]         f_d;
    logic                   b_q;
    logic                   b_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   accept_s;

    // Last synchronizer stage is the only version of a the rest of the cell sees.
    assign sync_out_s = sync_q[SYNC_STAGES-1];

    // Synchronizer next state: shift a in at the low end.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], a};
    end

    // Stability filter: b follows the synchronized input only after it has
    // disagreed with b for STABLE_CYCLES consecutive samples. Any agreeing
    // sample restarts the count, so short glitches never reach b.
    always_comb begin
        f_d      = f_q;
        b_d      = b_q;
        accept_s = 1'b0;
        if (sync_out_s == b_q) begin
            f_d = F_ZERO;
        end else if (f_q == F_LAST) begin
            b_d      = sync_out_s;
            f_d      = F_ZERO;
            accept_s = 1'b1;
        end else begin
            f_d = f_q + F_ONE;
        end
    end

    // Edge pulses are registered alongside b, so they line up with its change.
    always_comb begin
        if (accept_s) begin
            rise_d = sync_out_s;
            fall_d = ~sync_out_s;
        end else begin
            rise_d = 1'b0;
            fall_d = 1'b0;
        end
    end

    // Transition counter: clear takes priority over a coincident transition.
    always_comb begin
        if (cnt_clr) begin
            cnt_d = CNT_ZERO;
        end else if (accept_s) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset drops everything at once, including any pending change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            f_q    <= F_ZERO;
            b_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= CNT_ZERO;
        end else begin
            sync_q <= sync_d;
            f_q    <= f_d;
            b_q    <= b_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign b        = b_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_hello_follower.sv
// -----------------------------------------------------------------------------
// tb_hello_follower
//
// Three follower instances with different parameter sets share clk and rst_n.
//   u0 : defaults            (SYNC=2, STABLE=1, CNT_W=16)
//   u1 : deeper + filtered   (SYNC=3, STABLE=4, CNT_W=16)
//   u2 : narrow counter      (SYNC=2, STABLE=1, CNT_W=2)
//
// A reference model runs on every rising edge. It keeps the full history of a
// and applies the rule "b flips once the STABLE most recent synchronized
// samples (a delayed by SYNC edges) all differ from b". It pushes the expected
// outputs into one queue per instance. A monitor pops those entries 1 ns after
// each edge and compares them with the DUT outputs. Directed checks cover the
// latency, saturation, clear priority and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_hello_follower;

    typedef struct {
        bit          b;
        bit          rise;
        bit          fall;
        int unsigned cnt;
    } exp_t;

    localparam int SYNC_P [3] = '{2, 3, 2};
    localparam int STAB_P [3] = '{1, 4, 1};
    localparam int CMAX_P [3] = '{65535, 65535, 3};

    logic        clk;
    logic        rst_n;
    logic [2:0]  a_v;
    logic [2:0]  clr_v;
    logic [2:0]  b_v;
    logic [2:0]  rise_v;
    logic [2:0]  fall_v;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int total;
    int bad;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    bit          hist [3][16];
    bit          mb   [3];
    int unsigned mcnt [3];

    hello_follower u0 (
        .clk(clk), .rst_n(rst_n), .a(a_v[0]), .cnt_clr(clr_v[0]),
        .b(b_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .edge_cnt(cnt0)
    );

    hello_follower #(.SYNC_STAGES(3), .STABLE_CYCLES(4), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a_v[1]), .cnt_clr(clr_v[1]),
        .b(b_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .edge_cnt(cnt1)
    );

    hello_follower #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .a(a_v[2]), .cnt_clr(clr_v[2]),
        .b(b_v[2]), .rise(rise_v[2]), .fall(fall_v[2]), .edge_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history-window rule, one expected entry per instance per edge.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            bit   all_diff;
            if (!rst_n) begin
                for (int j = 0; j < 16; j++) hist[i][j] = 1'b0;
                mb[i]   = 1'b0;
                mcnt[i] = 0;
                e.b = 1'b0; e.rise = 1'b0; e.fall = 1'b0; e.cnt = 0;
            end else begin
                for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = a_v[i];
                all_diff = 1'b1;
                for (int k = 0; k < STAB_P[i]; k++)
                    if (hist[i][SYNC_P[i] + k] == mb[i]) all_diff = 1'b0;
                e.rise = all_diff && !mb[i];
                e.fall = all_diff && mb[i];
                if (all_diff) mb[i] = !mb[i];
                if (clr_v[i])
                    mcnt[i] = 0;
                else if (all_diff && mcnt[i] < CMAX_P[i])
                    mcnt[i] = mcnt[i] + 1;
                e.b   = mb[i];
                e.cnt = mcnt[i];
            end
            case (i)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    end

    // Monitor: pop each expected entry and compare it with the DUT after the edge.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_t        e;
            bit          have;
            logic [31:0] act_cnt;
            have = 1'b1;
            case (i)
                0: begin
                    if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
                    act_cnt = {16'd0, cnt0};
                end
                1: begin
                    if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
                    act_cnt = {16'd0, cnt1};
                end
                default: begin
                    if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
                    act_cnt = {30'd0, cnt2};
                end
            endcase
            if (!have) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", i);
            end else begin
                chk($sformatf("sb_b[%0d]", i),    {31'd0, b_v[i]},    {31'd0, e.b});
                chk($sformatf("sb_rise[%0d]", i), {31'd0, rise_v[i]}, {31'd0, e.rise});
                chk($sformatf("sb_fall[%0d]", i), {31'd0, fall_v[i]}, {31'd0, e.fall});
                chk($sformatf("sb_cnt[%0d]", i),  act_cnt,            e.cnt);
            end
        end
    end

    // Time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a_v   = 3'b000;
        clr_v = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_b", {29'd0, b_v}, 32'd0);
        chk("reset_cnt0", {16'd0, cnt0}, 32'd0);

        // Defaults: b follows 2 edges after capture, with single pulses.
        a_v[0] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            chk("u0_rise_b",    {31'd0, b_v[0]},    {31'd0, (e >= 3) ? 1'b1 : 1'b0});
            chk("u0_rise_rise", {31'd0, rise_v[0]}, {31'd0, (e == 3) ? 1'b1 : 1'b0});
        end
        @(negedge clk);
        a_v[0] = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            chk("u0_fall_b",    {31'd0, b_v[0]},    {31'd0, (e >= 3) ? 1'b0 : 1'b1});
            chk("u0_fall_fall", {31'd0, fall_v[0]}, {31'd0, (e == 3) ? 1'b1 : 1'b0});
        end
        chk("u0_cnt_two", {16'd0, cnt0}, 32'd2);

        // Filtered instance: a 2-cycle pulse is rejected.
        @(negedge clk);
        a_v[1] = 1'b1;
        repeat (2) @(negedge clk);
        a_v[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("u1_glitch_b",   {31'd0, b_v[1]}, 32'd0);
        chk("u1_glitch_cnt", {16'd0, cnt1},   32'd0);
        // A held level is accepted at capture + SYNC(3) + STABLE(4) - 1 = 7th edge.
        a_v[1] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            chk("u1_hold_b", {31'd0, b_v[1]}, {31'd0, (e >= 7) ? 1'b1 : 1'b0});
        end

        // Narrow counter saturates at 3 after 10 transitions.
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            a_v[2] = 1'b1;
            repeat (3) @(negedge clk);
            a_v[2] = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("u2_sat_cnt", {30'd0, cnt2}, 32'd3);
        chk("u2_sat_b",   {31'd0, b_v[2]}, 32'd0);
        // A clear on the same edge as a transition wins.
        a_v[2] = 1'b1;
        repeat (2) @(negedge clk);
        clr_v[2] = 1'b1;
        @(negedge clk);
        clr_v[2] = 1'b0;
        chk("u2_clr_cnt", {30'd0, cnt2},   32'd0);
        chk("u2_clr_b",   {31'd0, b_v[2]}, 32'd1);

        // Random phase: mostly held levels, with occasional toggles and clears.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) a_v[i] = ~a_v[i];
                clr_v[i] = ($urandom_range(0, 31) == 0);
            end
        end

        // Asynchronous reset while b=1 and a change is pending on u0.
        @(negedge clk);
        a_v   = 3'b111;
        clr_v = 3'b000;
        repeat (10) @(negedge clk);
        chk("pre_reset_b", {29'd0, b_v}, 32'd7);
        a_v[0] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_b",    {29'd0, b_v},    32'd0);
        chk("async_rise", {29'd0, rise_v}, 32'd0);
        chk("async_fall", {29'd0, fall_v}, 32'd0);
        chk("async_cnt0", {16'd0, cnt0},   32'd0);
        chk("async_cnt1", {16'd0, cnt1},   32'd0);
        chk("async_cnt2", {30'd0, cnt2},   32'd0);
        a_v = 3'b111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // b returns after SYNC+STABLE edges: 3 for u0/u2, 7 for u1.
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            chk("rel_b0", {31'd0, b_v[0]}, {31'd0, (e >= 3) ? 1'b1 : 1'b0});
            chk("rel_b1", {31'd0, b_v[1]}, {31'd0, (e >= 7) ? 1'b1 : 1'b0});
            chk("rel_b2", {31'd0, b_v[2]}, {31'd0, (e >= 3) ? 1'b1 : 1'b0});
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
